dep_dispatch_arbiter: RTL and testbench
=======================================

# dep_dispatch_arbiter

Parametrised dependency-aware dispatcher between the instruction fetch stream and NUM_CORES execution cores. Each incoming instruction is placed into one per-core queue. Placement is round-robin unless the instruction has a read-after-write, write-after-read or write-after-write hazard against an entry still queued for some core; such an instruction is steered to that same core so it executes in order. Each queue presents a valid/ready output to its core.

## Interface
- DATA_W, 32: instruction width; must be ≥ 2*ADDR_W+2.
- ADDR_W, 11: operand address width. Fields are:
  - src = [ADDR_W-1:0]
  - dest = [2*ADDR_W-1:ADDR_W]
  - dest flag = bit 2*ADDR_W
  - src flag = bit 2*ADDR_W+1
- NUM_CORES, 2: number of cores/queues, ≥2.
- QUEUE_DEPTH, 8: entries per queue, power of two ≥2.
- CNT_W (derived localparam) = $clog2(QUEUE_DEPTH+1).

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_data  in  DATA_W  instruction.
- in_ready  out  1  dispatcher accepts in_data this cycle (combinational from state and in_data).
- out_valid  out  NUM_CORES  per-core queue non-empty.
- out_data  out  NUM_CORES*DATA_W  per-core head entry; core c at [c*DATA_W +: DATA_W].
- out_ready  in  NUM_CORES  core c pops its head when out_valid[c]&&out_ready[c].
- occupancy  out  NUM_CORES*CNT_W  per-core entry count.
- stall_cnt  out  16  saturating count of cycles with in_valid=1 and in_ready=0.

## Operation
- Operand key = {flag, address}. Src key = {src flag, src}; dest key = {dest flag, dest}.
- Instruction with both flags = 1 is operand-free: no hazard check, round-robin placement.
- Hazard check: compare the new instruction against every occupied entry of every queue. An entry is "queued" from its push edge until its pop edge; popped entries are retired and ignored.
  - RAW: new src key == entry dest key.
  - WAR: new dest key == entry src key.
  - WAW: new dest key == entry dest key.
- conflict[c] = any hazard against any entry of queue c.
- Target selection:
  - No conflicts: first non-full core scanning from rr_ptr upward, wrapping modulo NUM_CORES.
  - Exactly one conflict[c]: target = c, regardless of rr_ptr.
  - Two or more conflicts: stall. in_ready=0 until queues drain to at most one conflicting core.
  - Target full, or all queues full in the no-conflict case: stall.
- Accept = in_valid && in_ready. On accept, push to the target's tail.
- rr_ptr update: on a no-conflict accept, rr_ptr ← target+1 (mod NUM_CORES). On a steered accept, rr_ptr is unchanged.
- Each queue is a circular buffer with wr/rd pointers of $clog2(QUEUE_DEPTH) bits that wrap naturally, plus a count.
- Full (count == QUEUE_DEPTH) blocks a push even if a pop happens the same cycle.
- Simultaneous push and pop on a non-full queue: count unchanged, both pointers advance.
- stall_cnt holds at 16'hFFFF once saturated.

## Timing
- Reset (async assert, synchronous-safe release) sets:
  - all queues empty, occupancy all 0
  - out_valid=0, out_data=0
  - rr_ptr=0, stall_cnt=0
  - in_ready then follows the selection rules (1 with empty queues).
- Reset mid-operation discards all queued instructions; no partial pushes or pops.
- Latency: an instruction accepted at edge N is visible on out_valid/out_data after edge N (usable in cycle N+1) if its queue was empty.
- out_data of an empty queue = 0.
- A pop at edge N frees that entry for the hazard check from cycle N+1.
- in_ready may depend on in_data. Sources must hold in_data stable while in_valid=1 and in_ready=0.
- Throughput: one accept per cycle; one pop per core per cycle.

## Test plan
- Round-robin, defaults: push 0x00002801, 0x00003002, 0x00003803 (distinct operands), out_ready=0 → cores 0, 1, 0; occupancy {2,1}; rr_ptr=1.
- RAW steer: core0 holds 0x00002801 (dest 5); push 0x00000005 (src 5) with rr_ptr=1 → lands in core0; rr_ptr stays 1.
- Multi-conflict stall: core0 holds dest 5, core1 holds dest 6; offer src 5 / dest 6 (0x00003005) → in_ready=0 and stall_cnt increments each cycle. Pop core1 → accepted to core0 the next cycle.
- Full queue: QUEUE_DEPTH=4, fill core0 via steering. A fifth steered instruction stalls even with out_ready[0]=1 that cycle; it is accepted the following cycle. Pointer wrap preserves FIFO order across 12 push/pop pairs.
- Operand-free: both flags set (0x00C00000) while every queue holds matching addresses → no steering, round-robin placement.
- Async reset: assert resetn=0 mid-burst between edges → out_valid=0, occupancy=0, stall_cnt=0 immediately; first post-reset push goes to core0.

Source files
------------

// File: rtl/dep_dispatch_arbiter.sv
// Dispatches the fetch stream into per-core FIFOs. An instruction that has a RAW/WAR/WAW hazard
// against an instruction still queued is kept on that core; all other instructions go round-robin.
module dep_dispatch_arbiter #(
    parameter  int DATA_W      = 32,
    parameter  int ADDR_W      = 11,
    parameter  int NUM_CORES   = 2,
    parameter  int QUEUE_DEPTH = 8,
    localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [NUM_CORES-1:0]          out_valid,
    output logic [NUM_CORES*DATA_W-1:0]   out_data,
    input  logic [NUM_CORES-1:0]          out_ready,
    output logic [NUM_CORES*CNT_W-1:0]    occupancy,
    output logic [15:0]                   stall_cnt
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int RR_W  = $clog2(NUM_CORES);
    localparam int KEY_W = ADDR_W + 1;

    function automatic logic [KEY_W-1:0] src_key(input logic [DATA_W-1:0] d);
        return {d[2*ADDR_W+1], d[ADDR_W-1:0]};
    endfunction

    function automatic logic [KEY_W-1:0] dest_key(input logic [DATA_W-1:0] d);
        return {d[2*ADDR_W], d[2*ADDR_W-1:ADDR_W]};
    endfunction

    logic [DATA_W-1:0]    mem_q    [NUM_CORES][QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_CORES];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_CORES];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_CORES];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_CORES];
    logic [CNT_W-1:0]     cnt_q    [NUM_CORES];
    logic [CNT_W-1:0]     cnt_d    [NUM_CORES];
    logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;

    logic [NUM_CORES-1:0] conflict, full, push, pop;
    logic [RR_W-1:0]      target;
    logic                 steered;
    logic                 accept;
    logic                 operand_free;

    assign operand_free = in_data[2*ADDR_W+1] & in_data[2*ADDR_W];
    assign accept       = in_valid & in_ready;
    assign stall_cnt    = stall_cnt_q;

    // An entry is live when its slot lies within count slots of the read pointer.
    always_comb begin : hazard_check
        logic [PTR_W-1:0] off;
        off      = '0;
        conflict = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                off = PTR_W'(e) - rd_ptr_q[c];
                if (!operand_free && (CNT_W'(off) < cnt_q[c]) &&
                    ((src_key(in_data)  == dest_key(mem_q[c][e])) ||
                     (dest_key(in_data) == src_key(mem_q[c][e]))  ||
                     (dest_key(in_data) == dest_key(mem_q[c][e]))))
                    conflict[c] = 1'b1;
            end
        end
    end

    always_comb begin : select_target
        int              idx;
        logic            any_conf;
        logic            multi_conf;
        logic [RR_W-1:0] conf_idx;
        idx        = 0;
        any_conf   = 1'b0;
        multi_conf = 1'b0;
        conf_idx   = '0;
        target     = '0;
        steered    = 1'b0;
        in_ready   = 1'b0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (conflict[c]) begin
                multi_conf = multi_conf | any_conf;
                any_conf   = 1'b1;
                conf_idx   = RR_W'(c);
            end
        end
        if (multi_conf) begin
            in_ready = 1'b0;
        end else if (any_conf) begin
            target   = conf_idx;
            steered  = 1'b1;
            in_ready = !full[conf_idx];
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                idx = (int'(rr_ptr_q) + k) % NUM_CORES;
                if (!in_ready && !full[idx]) begin
                    in_ready = 1'b1;
                    target   = RR_W'(idx);
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_queue
        assign out_valid[c]                    = (cnt_q[c] != '0);
        assign full[c]                         = (cnt_q[c] == CNT_W'(QUEUE_DEPTH));
        assign pop[c]                          = out_valid[c] & out_ready[c];
        assign push[c]                         = accept & (target == RR_W'(c));
        assign out_data[c*DATA_W +: DATA_W]    = out_valid[c] ? mem_q[c][rd_ptr_q[c]] : '0;
        assign occupancy[c*CNT_W +: CNT_W]     = cnt_q[c];
    end

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            wr_ptr_d[c] = push[c] ? wr_ptr_q[c] + PTR_W'(1) : wr_ptr_q[c];
            rd_ptr_d[c] = pop[c]  ? rd_ptr_q[c] + PTR_W'(1) : rd_ptr_q[c];
            cnt_d[c]    = cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
        end
        rr_ptr_d = rr_ptr_q;
        if (accept && !steered)
            rr_ptr_d = (target == RR_W'(NUM_CORES - 1)) ? '0 : target + RR_W'(1);
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Storage needs no reset: slots outside the live window are never observed.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CORES; c++) begin
            if (push[c])
                mem_q[c][wr_ptr_q[c]] <= in_data;
        end
    end

endmodule

// File: tb/tb_dep_dispatch_arbiter.sv
// Directed bench for dep_dispatch_arbiter (2 cores, depth 4) with hand-computed expectations.
module tb_dep_dispatch_arbiter;
    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        in_valid  = 1'b0;
    logic [31:0] in_data   = '0;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_ready = '0;
    logic [5:0]  occupancy;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dep_dispatch_arbiter #(
        .DATA_W(32), .ADDR_W(11), .NUM_CORES(2), .QUEUE_DEPTH(4)
    ) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check_eq(tag, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_occ",   64'(occupancy), 64'd0);
        check_eq("rst_stall", 64'(stall_cnt), 64'd0);
        check_eq("rst_data",  out_data,       64'd0);
        check_eq("rst_ready", 64'(in_ready),  64'd1);

        // round-robin with distinct operands
        push(32'h0000_2801, "rr_a_rdy");
        check_eq("rr_a_valid", 64'(out_valid), 64'b01);
        push(32'h0000_3002, "rr_b_rdy");
        push(32'h0000_3803, "rr_c_rdy");
        check_eq("rr_occ",  64'(occupancy), 64'({3'd1, 3'd2}));
        check_eq("rr_data", out_data,       {32'h0000_3002, 32'h0000_2801});

        // RAW steer to core0 with rr_ptr=1
        push(32'h0000_0005, "raw_rdy");
        check_eq("raw_occ", 64'(occupancy), 64'({3'd1, 3'd3}));
        // steer to core1 while rr_ptr=1: rr_ptr must not move
        push(32'h0000_4806, "st1_rdy");
        check_eq("st1_occ", 64'(occupancy), 64'({3'd2, 3'd3}));
        push(32'h0000_5008, "rrkeep_rdy");
        check_eq("rrkeep_occ",  64'(occupancy), 64'({3'd3, 3'd3}));
        check_eq("rrkeep_data", out_data,       {32'h0000_3002, 32'h0000_2801});

        // multi-conflict stall
        do_reset();
        push(32'h0000_2801, "mc_a_rdy");
        push(32'h0000_3002, "mc_b_rdy");
        in_valid = 1'b1;
        in_data  = 32'h0000_3005;
        #1;
        check_eq("mc_stall_rdy", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("mc_stall_cnt3", 64'(stall_cnt), 64'd3);
        out_ready = 2'b10;
        @(posedge clk);
        #1;
        out_ready = 2'b00;
        check_eq("mc_stall_cnt4", 64'(stall_cnt), 64'd4);
        #1;
        check_eq("mc_pop_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("mc_occ",   64'(occupancy), 64'({3'd0, 3'd2}));
        check_eq("mc_stall", 64'(stall_cnt), 64'd4);
        check_eq("mc_head",  out_data,       {32'h0, 32'h0000_2801});

        // full queue blocks push despite same-cycle pop
        do_reset();
        push(32'h0000_2801, "full_a_rdy");
        push(32'h0000_0005, "full_b_rdy");
        push(32'h0000_0805, "full_c_rdy");
        push(32'h0000_1005, "full_d_rdy");
        check_eq("full_occ4", 64'(occupancy), 64'd4);
        in_valid  = 1'b1;
        in_data   = 32'h0000_0000;
        out_ready = 2'b01;
        #1;
        check_eq("full_blk_rdy", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 2'b00;
        check_eq("full_occ3",  64'(occupancy), 64'd3);
        check_eq("full_stall", 64'(stall_cnt), 64'd1);
        check_eq("full_head",  out_data,       {32'h0, 32'h0000_0005});
        #1;
        check_eq("full_next_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("full_occ_after", 64'(occupancy), 64'd4);

        // pointer wrap: 12 push/pop pairs, FIFO order on core0
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h800 | (32'h10 + 32'(i)), "wrap_fill_rdy");
        check_eq("wrap_occ_fill", 64'(occupancy), 64'd3);
        for (int k = 0; k < 12; k++) begin
            in_valid  = 1'b1;
            in_data   = 32'h800 | (32'h10 + 32'(k + 3));
            out_ready = 2'b01;
            #1;
            check_eq("wrap_head", 64'(out_data[31:0]), 64'(32'h800 | (32'h10 + 32'(k))));
            check_eq("wrap_rdy",  64'(in_ready),       64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("wrap_occ_pairs", 64'(occupancy), 64'd3);
        for (int k = 12; k < 15; k++) begin
            check_eq("wrap_drain", 64'(out_data[31:0]), 64'(32'h800 | (32'h10 + 32'(k))));
            out_ready = 2'b01;
            @(posedge clk);
            #1;
        end
        out_ready = 2'b00;
        check_eq("wrap_empty_occ",  64'(occupancy), 64'd0);
        check_eq("wrap_empty_data", out_data,       64'd0);

        // operand-free instructions ignore hazards
        do_reset();
        push(32'h0040_0000, "of_a_rdy");
        push(32'h00C0_0000, "of_b_rdy");
        check_eq("of_occ1", 64'(occupancy), 64'({3'd1, 3'd1}));
        push(32'h00C0_0000, "of_c_rdy");
        check_eq("of_occ2", 64'(occupancy), 64'({3'd1, 3'd2}));
        push(32'h00C0_0000, "of_d_rdy");
        check_eq("of_occ3", 64'(occupancy), 64'({3'd2, 3'd2}));

        // async reset between edges
        do_reset();
        push(32'h0000_2801, "ar_a_rdy");
        push(32'h0000_3002, "ar_b_rdy");
        in_valid = 1'b1;
        in_data  = 32'h0000_3005;
        repeat (2) @(posedge clk);
        #1;
        check_eq("ar_stall_pre", 64'(stall_cnt), 64'd2);
        #2;
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        check_eq("ar_valid", 64'(out_valid), 64'd0);
        check_eq("ar_occ",   64'(occupancy), 64'd0);
        check_eq("ar_stall", 64'(stall_cnt), 64'd0);
        check_eq("ar_data",  out_data,       64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        push(32'h0000_3803, "ar_post_rdy");
        check_eq("ar_post_valid", 64'(out_valid), 64'b01);
        check_eq("ar_post_data",  out_data,       {32'h0, 32'h0000_3803});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
